n64_deblur_est: RTL

Parametrised blur estimator and de-blur blanking controller for the N64 video input path. It sits between the input demux (data_cnt / nDSYNC phase tracking) and the RGB output stage. It decides per frame whether the N64 is rendering with its blur filter enabled and drives pixel blanking for 240p de-blur. Compared with the fixed-width estimator, it adds configurable colour width, compare range, trend depth and border skip, hysteretic decision thresholds, and status outputs for the OSD.

---
 rtl/n64_deblur_est_if.sv | 37 +++
 rtl/n64_deblur_est.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/n64_deblur_est_if.sv
// Pixel-bus bundle between the N64 input demux and the blur estimator.
// Latency: none (wires only).
// Backpressure: none; the pixel bus is free-running, one word per nCLK.
// Ports: demux side drives nDSYNC, sync/pixel vectors, data_cnt and mode
//        controls; the estimator drives ndo_deblur, nblank_rgb, nblur_n64
//        and trend_o.
interface n64_deblur_est_if #(
    parameter int COLOR_WIDTH = 7,
    parameter int TREND_WIDTH = 9
);
    logic                       nDSYNC;
    logic [3:0]                 vdata_sync_2pre;
    logic [3*COLOR_WIDTH+3:0]   vdata_pre;
    logic [COLOR_WIDTH-1:0]     vdata_cur;
    logic [1:0]                 data_cnt;
    logic                       n64_480i;
    logic                       vmode;
    logic                       blurry_pixel_pos;
    logic                       nForceDeBlur;
    logic                       nDeBlurMan;
    logic                       ndo_deblur;
    logic                       nblank_rgb;
    logic                       nblur_n64;
    logic [TREND_WIDTH-1:0]     trend_o;

    modport master (
        output nDSYNC, vdata_sync_2pre, vdata_pre, vdata_cur, data_cnt,
               n64_480i, vmode, blurry_pixel_pos, nForceDeBlur, nDeBlurMan,
        input  ndo_deblur, nblank_rgb, nblur_n64, trend_o
    );

    modport slave (
        input  nDSYNC, vdata_sync_2pre, vdata_pre, vdata_cur, data_cnt,
               n64_480i, vmode, blurry_pixel_pos, nForceDeBlur, nDeBlurMan,
        output ndo_deblur, nblank_rgb, nblur_n64, trend_o
    );
endinterface

// File: rtl/n64_deblur_est.sv
// Per-frame N64 blur-filter estimator with hysteretic trend and 240p de-blur blanking.
// Latency: all outputs registered on negedge nCLK; trend one cycle after frame start.
// Backpressure: none; consumes one bus word per nCLK unconditionally.
// Ports: nCLK (falling-edge clock), DRV_RST (sync active-high reset),
//        bus (slave side of n64_deblur_est_if: pixel bus in, estimate/blanking out).
module n64_deblur_est #(
    parameter int COLOR_WIDTH   = 7,
    parameter int CMP_MSB       = COLOR_WIDTH - 1,
    parameter int CMP_LSB       = COLOR_WIDTH - 2,
    parameter int TREND_WIDTH   = 9,
    parameter int TH_HI         = 2**(TREND_WIDTH-1) + 16,
    parameter int TH_LO         = 2**(TREND_WIDTH-1) - 16,
    parameter int EST_CNT_WIDTH = 2,
    parameter int EST_TH        = 2,
    parameter int HOLDOFF_WIDTH = 2,
    parameter int BORDER_SKIP   = 3
) (
    input  logic            nCLK,
    input  logic            DRV_RST,
    n64_deblur_est_if.slave bus
);
    localparam int CW     = COLOR_WIDTH;
    localparam int CMP_W  = CMP_MSB - CMP_LSB + 1;
    localparam int SKIP_W = ($clog2(BORDER_SKIP + 1) > 0) ? $clog2(BORDER_SKIP + 1) : 1;
    localparam int PRE_VS = 3*CW + 3;
    localparam int PRE_HS = 3*CW + 1;
    localparam int PRE_CS = 3*CW;

    localparam logic [SKIP_W-1:0]        SKIP_MAX   = SKIP_W'(BORDER_SKIP);
    localparam logic [EST_CNT_WIDTH-1:0] EST_TH_V   = EST_CNT_WIDTH'(EST_TH);
    localparam logic [TREND_WIDTH-1:0]   TREND_INIT = TREND_WIDTH'(2**(TREND_WIDTH-1));
    localparam logic [TREND_WIDTH-1:0]   TH_HI_V    = TREND_WIDTH'(TH_HI);
    localparam logic [TREND_WIDTH-1:0]   TH_LO_V    = TREND_WIDTH'(TH_LO);

    logic [1:0]               r_grad_r, r_grad_g, r_grad_b;
    logic [1:0]               r_chg;
    logic [SKIP_W-1:0]        r_skip;
    logic [HOLDOFF_WIDTH-1:0] r_holdoff;
    logic [EST_CNT_WIDTH-1:0] r_est_cnt;
    logic [TREND_WIDTH-1:0]   r_trend;
    logic                     r_nblur;
    logic                     r_ndo_deblur;
    logic                     r_nblank;

    logic             w_act_window, w_line_start, w_frame_start;
    logic [CMP_W-1:0] w_pre_cmp, w_cur_cmp;
    logic [1:0]       w_code, w_grad_old;
    logic             w_comp_vld, w_reversal, w_skip_done;
    logic             w_unused;

    // Only the sync flags and the compare slices matter; the rest of the
    // bus is carried for the downstream stages.
    assign w_unused = ^{bus.vdata_pre, bus.vdata_sync_2pre, bus.vdata_cur};

    assign w_act_window  = bus.vdata_sync_2pre[3] & bus.vdata_sync_2pre[1] &
                           bus.vdata_pre[PRE_VS] & bus.vdata_pre[PRE_HS];
    assign w_line_start  = ~bus.nDSYNC & ~bus.vdata_pre[PRE_CS] & bus.vdata_cur[0];
    assign w_frame_start = ~bus.nDSYNC & bus.vdata_pre[PRE_VS] & ~bus.vdata_cur[3];

    assign w_cur_cmp = bus.vdata_cur[CMP_MSB -: CMP_W];

    always_comb begin
        w_pre_cmp  = '0;
        w_grad_old = 2'b00;
        w_comp_vld = 1'b0;
        case (bus.data_cnt)
            2'd1: begin
                w_pre_cmp  = bus.vdata_pre[2*CW + CMP_MSB -: CMP_W];
                w_grad_old = r_grad_r;
                w_comp_vld = 1'b1;
            end
            2'd2: begin
                w_pre_cmp  = bus.vdata_pre[CW + CMP_MSB -: CMP_W];
                w_grad_old = r_grad_g;
                w_comp_vld = 1'b1;
            end
            2'd3: begin
                w_pre_cmp  = bus.vdata_pre[CMP_MSB -: CMP_W];
                w_grad_old = r_grad_b;
                w_comp_vld = 1'b1;
            end
            default: ;
        endcase
    end

    // {rising, falling}: a reversal is a stored rise meeting a new fall or vice versa
    assign w_code      = {w_pre_cmp < w_cur_cmp, w_pre_cmp > w_cur_cmp};
    assign w_reversal  = w_comp_vld & ((w_grad_old ^ w_code) == 2'b11);
    assign w_skip_done = (r_skip == SKIP_MAX);

    always_ff @(negedge nCLK) begin
        if (DRV_RST) begin
            r_grad_r     <= 2'b00;
            r_grad_g     <= 2'b00;
            r_grad_b     <= 2'b00;
            r_chg        <= 2'd0;
            r_skip       <= '0;
            r_holdoff    <= '0;
            r_est_cnt    <= '0;
            r_trend      <= TREND_INIT;
            r_nblur      <= 1'b1;
            r_ndo_deblur <= 1'b1;
            r_nblank     <= 1'b1;
        end else begin
            if (bus.nDSYNC) begin
                if (w_act_window && bus.blurry_pixel_pos) begin
                    case (bus.data_cnt)
                        2'd1:    r_grad_r <= w_code;
                        2'd2:    r_grad_g <= w_code;
                        2'd3:    r_grad_b <= w_code;
                        default: ;
                    endcase
                end else if (w_act_window && w_skip_done && w_reversal) begin
                    // R opens a new pixel's tally; G and B add to it
                    if (bus.data_cnt == 2'd1)
                        r_chg <= 2'd1;
                    else
                        r_chg <= r_chg + 2'd1;
                end
            end else if (!bus.blurry_pixel_pos) begin
                if (r_skip != SKIP_MAX)
                    r_skip <= r_skip + 1'b1;
                if (r_holdoff != '0)
                    r_holdoff <= r_holdoff + 1'b1;
                // Event only when all three components reversed together
                if (r_chg == 2'd3) begin
                    if (r_est_cnt < EST_TH_V && r_holdoff == '0)
                        r_est_cnt <= r_est_cnt + 1'b1;
                    r_holdoff <= HOLDOFF_WIDTH'(1);
                end
                r_chg <= 2'd0;
            end

            if (!w_act_window) begin
                r_grad_r <= 2'b00;
                r_grad_g <= 2'b00;
                r_grad_b <= 2'b00;
                r_skip   <= '0;
            end

            if (w_line_start) begin
                r_skip    <= '0;
                r_holdoff <= '0;
            end

            if (w_frame_start) begin
                if (r_est_cnt >= EST_TH_V) begin
                    if (r_trend != '1)
                        r_trend <= r_trend + 1'b1;
                end else if (r_trend != '0) begin
                    r_trend <= r_trend - 1'b1;
                end
                // Hysteresis band between TH_LO and TH_HI keeps the estimate
                if (r_trend >= TH_HI_V)
                    r_nblur <= 1'b1;
                else if (r_trend < TH_LO_V)
                    r_nblur <= 1'b0;
                r_est_cnt    <= '0;
                r_ndo_deblur <= bus.n64_480i | (bus.nForceDeBlur ? r_nblur : bus.nDeBlurMan);
            end

            // Interlaced video has no blur filter: pin the estimator at neutral
            if (bus.n64_480i) begin
                r_trend <= TREND_INIT;
                r_nblur <= 1'b1;
            end

            if (!bus.nDSYNC) begin
                if (r_ndo_deblur)
                    r_nblank <= 1'b1;
                else if (w_line_start)
                    r_nblank <= bus.vmode;
                else
                    r_nblank <= ~r_nblank;
            end
        end
    end

    assign bus.ndo_deblur = r_ndo_deblur;
    assign bus.nblank_rgb = r_nblank;
    assign bus.nblur_n64  = r_nblur;
    assign bus.trend_o    = r_trend;
endmodule
